// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches, masks and prioritises requests,
// pulses interrput once per dispatch and holds service until EOI. IRQ_EDGE_EN selects edge-triggered requests.
module irq_controller #(
  parameter int          N_IRQ     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             wr_en,
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             interrput,
  output logic [4:0]       irq_id,
  output logic             in_service
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] pending_q, mask_q;
  logic [N_IRQ-1:0] set_v, clr_v, req_v;
  logic [4:0]       id_q, id_d;
  logic             sel, wr_pend, wr_mask, wr_eoi, eoi_fire;

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_pend  = sel && wr_en && (addr[3:2] == 2'd0);
  assign wr_mask  = sel && wr_en && (addr[3:2] == 2'd1);
  assign wr_eoi   = sel && wr_en && (addr[3:2] == 2'd3);
  assign eoi_fire = wr_eoi && (state_q == SERVICE);
  assign req_v    = pending_q & mask_q;

`ifdef IRQ_EDGE_EN
  // src_q holds last cycle's lines so a held level only pends once.
  logic [N_IRQ-1:0] src_q;
  always_ff @(posedge clk) begin
    if (!rst_n) src_q <= '0;
    else        src_q <= irq_src;
  end
  assign set_v = irq_src & ~src_q;
`else
  assign set_v = irq_src;
`endif

  always_comb begin
    clr_v = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_v[i] = (wr_pend && wr_data[i]) || (eoi_fire && (id_q == 5'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= set_v | (pending_q & ~clr_v);
      if (wr_mask) mask_q <= wr_data[N_IRQ-1:0];
      id_q      <= id_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|req_v) begin
          // Descending scan leaves the lowest set index, i.e. highest priority.
          for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_v[i]) id_d = 5'(i);
          end
          state_d = ASSERT;
        end
      end
      ASSERT:  state_d = SERVICE;
      SERVICE: if (eoi_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign interrput  = (state_q == ASSERT);
  assign in_service = (state_q == ASSERT) || (state_q == SERVICE);
  assign irq_id     = id_q;

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (addr[3:2])
        2'd0:    rd_data = 32'(pending_q);
        2'd1:    rd_data = 32'(mask_q);
        2'd2:    rd_data = {in_service, 26'b0, id_q};
        default: rd_data = '0;
      endcase
    end
  end

endmodule
